// File: rtl/forth_dmem.sv
// forth_dmem: data-side memory and I/O page for the forth core.
// Holds a word-addressed RAM plus a memory-mapped I/O page. The page has a
// TX FIFO, an RX FIFO, a status register and a free-running cycle counter.
//
// Stream handshakes (tx_*, rx_*): a word moves on a rising edge exactly when
// valid and ready are both high at that edge. The producer holds its data
// stable while valid is high and ready is low. rx_ready and tx_valid come only
// from registered state and reset, never from the partner's valid/ready.
module forth_dmem #(
   parameter int RAM_WORDS  = 224,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  daddr,
   input  logic [15:0] ddata_write,
   input  logic        dwrite,
   output logic [15:0] ddata_read,
   output logic [15:0] tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [15:0] rx_data,
   input  logic        rx_valid,
   output logic        rx_ready
);

   localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [8:0] RAM_END = 9'(RAM_WORDS);

   localparam logic [7:0] A_TXDATA = 8'hF0;
   localparam logic [7:0] A_RXDATA = 8'hF1;
   localparam logic [7:0] A_STATUS = 8'hF2;
   localparam logic [7:0] A_CYCLE  = 8'hF3;

   logic [15:0] ram [RAM_WORDS];
   logic [15:0] tx_mem [FIFO_DEPTH];
   logic [15:0] rx_mem [FIFO_DEPTH];

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [PW:0] tx_wp, tx_rp, rx_wp, rx_rp;
   logic        tx_ovf, rx_unf;
   logic [15:0] cycle;

   logic in_ram;
   logic tx_full, tx_empty, rx_full, rx_empty;
   logic tx_push_req, tx_push, tx_pop, tx_ovf_set;
   logic rx_pop_req, rx_pop, rx_push, rx_unf_set;
   logic wr_status, wr_cycle;

   assign in_ram = ({1'b0, daddr} < RAM_END);

   assign tx_empty = (tx_wp == tx_rp);
   assign tx_full  = (tx_wp[PW] != tx_rp[PW]) && (tx_wp[PW-1:0] == tx_rp[PW-1:0]);
   assign rx_empty = (rx_wp == rx_rp);
   assign rx_full  = (rx_wp[PW] != rx_rp[PW]) && (rx_wp[PW-1:0] == rx_rp[PW-1:0]);

   assign tx_valid = !tx_empty && !reset;
   assign rx_ready = !rx_full && !reset;
   assign tx_data  = tx_mem[tx_rp[PW-1:0]];

   // All full/empty decisions use start-of-cycle state, so a pop in the same
   // cycle never makes room for a push to a full FIFO.
   assign tx_push_req = dwrite && (daddr == A_TXDATA);
   assign tx_push     = tx_push_req && !tx_full;
   assign tx_ovf_set  = tx_push_req && tx_full;
   assign tx_pop      = tx_valid && tx_ready;

   assign rx_pop_req  = dwrite && (daddr == A_RXDATA);
   assign rx_pop      = rx_pop_req && !rx_empty;
   assign rx_unf_set  = rx_pop_req && rx_empty;
   assign rx_push     = rx_valid && rx_ready;

   assign wr_status   = dwrite && (daddr == A_STATUS);
   assign wr_cycle    = dwrite && (daddr == A_CYCLE);

   // Storage arrays: RAM and FIFO slots are not reset; only pointers are.
   always_ff @(posedge clk) begin
      if (dwrite && in_ram)
         ram[daddr[AW-1:0]] <= ddata_write;
      if (tx_push)
         tx_mem[tx_wp[PW-1:0]] <= ddata_write;
      if (rx_push)
         rx_mem[rx_wp[PW-1:0]] <= rx_data;
   end

   // Pointers, sticky flags and cycle counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_wp  <= '0;
         tx_rp  <= '0;
         rx_wp  <= '0;
         rx_rp  <= '0;
         tx_ovf <= 1'b0;
         rx_unf <= 1'b0;
         cycle  <= '0;
      end else begin
         if (tx_push) tx_wp <= tx_wp + 1'b1;
         if (tx_pop)  tx_rp <= tx_rp + 1'b1;
         if (rx_push) rx_wp <= rx_wp + 1'b1;
         if (rx_pop)  rx_rp <= rx_rp + 1'b1;

         // A set event wins over a clear written in the same cycle.
         if (tx_ovf_set)
            tx_ovf <= 1'b1;
         else if (wr_status && ddata_write[4])
            tx_ovf <= 1'b0;

         if (rx_unf_set)
            rx_unf <= 1'b1;
         else if (wr_status && ddata_write[5])
            rx_unf <= 1'b0;

         // A load takes priority over the increment.
         if (wr_cycle)
            cycle <= ddata_write;
         else
            cycle <= cycle + 16'd1;
      end
   end

   // Combinational read mux; reads never change state.
   always_comb begin
      ddata_read = '0;
      if (in_ram) begin
         ddata_read = ram[daddr[AW-1:0]];
      end else begin
         case (daddr)
            A_RXDATA: ddata_read = rx_empty ? 16'd0 : rx_mem[rx_rp[PW-1:0]];
            A_STATUS: ddata_read = {10'd0, rx_unf, tx_ovf, rx_empty, rx_full,
                                    tx_empty, tx_full};
            A_CYCLE:  ddata_read = cycle;
            default:  ddata_read = '0;
         endcase
      end
   end

endmodule

// File: doc/forth_dmem.md
# forth_dmem

Data-side memory and I/O stage for the `forth` core. It sits directly on the core's data port (`daddr`/`ddata_write`/`ddata_read`/`dwrite`) and serves the core's memory accesses. It holds a small word-addressed RAM and a memory-mapped I/O page. The I/O page contains a transmit FIFO, a receive FIFO (each with a valid/ready stream to the outside world), a status register and a free-running cycle counter.

## Interface

Parameters:
- `RAM_WORDS`, 224: number of 16-bit RAM words, mapped at `0x00`..`RAM_WORDS-1`; must be ≤ 224.
- `FIFO_DEPTH`, 4: entries per FIFO; power of two, ≥ 2.

Ports:
- `clk`  in  1: single clock; everything is on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `daddr`  in  8: word address from the core.
- `ddata_write`  in  16: write data from the core.
- `dwrite`  in  1: write strobe; qualifies `daddr`/`ddata_write` this cycle.
- `ddata_read`  out  16: read data for `daddr`; combinational.
- `tx_data`  out  16: head of the TX FIFO.
- `tx_valid`  out  1: TX FIFO non-empty.
- `tx_ready`  in  1: consumer accepts `tx_data` when `tx_valid & tx_ready`.
- `rx_data`  in  16: producer word.
- `rx_valid`  in  1: producer offers `rx_data`.
- `rx_ready`  out  1: RX FIFO not full and not in reset.

## Operation

- **Reads** have no strobe. `ddata_read` is a pure function of `daddr` and the current register/RAM state in the same cycle. A read never changes state.
- **Writes** commit at the rising edge when `dwrite=1`.

Address map:
- `0x00`..`RAM_WORDS-1`, RAM:
  - Read returns the stored word.
  - Write stores `ddata_write`.
  - Contents are not reset.
- `0xF0` TXDATA:
  - Write pushes `ddata_write` if the TX FIFO is not full at the start of the cycle.
  - If it is full, the word is dropped and `tx_ovf` is set.
  - Read returns 0.
- `0xF1` RXDATA:
  - Read returns the RX head, or 0 when empty.
  - Write (data ignored) pops the head.
  - A pop while empty leaves the FIFO unchanged and sets `rx_unf`.
- `0xF2` STATUS:
  - Read returns: bit0 `tx_full`, bit1 `tx_empty`, bit2 `rx_full`, bit3 `rx_empty`, bit4 `tx_ovf`, bit5 `rx_unf`, bits 15:6 = 0.
  - Write: `ddata_write[4]=1` clears `tx_ovf`; `ddata_write[5]=1` clears `rx_unf`. Other bits are ignored.
- `0xF3` CYCLE:
  - Read returns the 16-bit counter.
  - Write loads `ddata_write`.
- All other addresses (`RAM_WORDS`..`0xEF`, `0xF4`..`0xFF`): read 0, write ignored.

FIFOs:
- Circular buffers with read/write pointers and a full flag (or an extra pointer bit).
- Occupancy is 0..`FIFO_DEPTH`.
- TX pop condition: `tx_valid & tx_ready`.
- RX push condition: `rx_valid & rx_ready`.
- Full/empty decisions use state at the start of the cycle:
  - A core push to a full TX FIFO is dropped even if a pop happens the same cycle.
  - Push and pop in the same cycle on a non-full, non-empty FIFO both take effect; occupancy is unchanged.
  - An RX pop and push in the same cycle with the FIFO empty: the pop underflows (`rx_unf` set) and the push is stored.
- Sticky flags: a set event and a clear write in the same cycle leave the flag set.

Cycle counter:
- Increments by 1 every cycle, wrapping `0xFFFF`→`0x0000`.
- A write to `0xF3` takes priority over the increment.

## Timing

- **Reset** (sampled at the edge while `reset=1`):
  - Both FIFOs empty, pointers 0, `tx_ovf=rx_unf=0`, counter 0.
  - `tx_valid=0`, `rx_ready=0` while `reset=1`; `rx_ready=1` from the first cycle after release.
  - Reset asserted mid-stream discards all FIFO contents. RAM is retained.
- **Read latency:** 0 cycles, combinational from `daddr`.
- **Write effects:** visible to reads from the cycle after the write edge.
- **TX path:** a word pushed at edge N gives `tx_valid=1` in cycle N+1 (no bypass).
- **RX path:** a word accepted at edge N is readable at `0xF1` in cycle N+1.
- **Flow control:** `tx_data` is stable while `tx_valid & !tx_ready`. `rx_ready` depends only on registered state and `reset`, never on `rx_valid`.
- **Counter:** equals k in the k-th cycle after reset release (0 in the first). After a load of V at edge N it reads V in cycle N+1 and V+1 in cycle N+2.

## Test plan

1. **RAM:** write `0x1234`→`0x05` and `0xBEEF`→`0xDF`, read back both; read `0xE5` → 0; write `0xE5` then read `0x05` → still `0x1234`.
2. **TX with stall:** hold `tx_ready=0`, write `0x0001`..`0x0005` to `0xF0`.
   - STATUS reads `tx_full=1`, `tx_ovf=1`.
   - Raise `tx_ready`: outputs 1,2,3,4 on consecutive cycles, then `tx_valid=0`.
   - Write `0x0010` to STATUS → `tx_ovf=0`.
3. **RX:** drive `rx_valid=1` with `0xA0`..`0xA5`; `rx_ready` drops after 4 accepts.
   - Read/pop `0xF1` four times → `0xA0`..`0xA3`.
   - A fifth pop → `rx_unf=1`, RXDATA reads 0.
4. **Simultaneous:**
   - With 2 TX words queued, a core push and a consumer pop in the same cycle → occupancy stays 2.
   - Full TX with push+pop in one cycle → pushed word dropped, `tx_ovf=1`.
   - Set+clear of `rx_unf` in one cycle → stays 1.
5. **Counter:** after reset it reads 0,1,2.
   - Write `0xFFFE` → reads `0xFFFE`, `0xFFFF`, `0x0000`.
6. **Reset mid-operation:** with 3 TX and 2 RX words queued, pulse `reset` for one cycle.
   - Afterwards `tx_valid=0`, STATUS = `0x000A`, counter 0, RAM word `0x05` unchanged.
